// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: funct codes, select width and the multiply sequencer states.
package mips_ctrl_pkg;

  localparam int unsigned SelW = 6;

  typedef logic [SelW-1:0] funct_t;

  localparam funct_t FunctAdd   = 6'd32;
  localparam funct_t FunctSub   = 6'd34;
  localparam funct_t FunctAnd   = 6'd36;
  localparam funct_t FunctOr    = 6'd37;
  localparam funct_t FunctSlt   = 6'd42;
  localparam funct_t FunctSrl   = 6'd2;
  localparam funct_t FunctMultu = 6'd25;
  localparam funct_t FunctMfhi  = 6'd16;
  localparam funct_t FunctMflo  = 6'd18;
  localparam funct_t FunctOut   = 6'd63;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StWrite
  } seq_state_e;

endpackage

// File: rtl/multu_sequencer_if.sv
// Decode-stage <-> multiply sequencer handshake bundle.
interface multu_sequencer_if;
  import mips_ctrl_pkg::*;

  logic   op_valid;
  funct_t funct;
  logic   abort;
  logic   mul_load;
  logic   mul_step;
  logic   hilo_we;
  funct_t sel_out;
  logic   busy;
  logic   stall;
  logic   done;

  // Decode side: issues instructions, observes control strobes.
  modport master (
    output op_valid, funct, abort,
    input  mul_load, mul_step, hilo_we, sel_out, busy, stall, done
  );

  // Sequencer side.
  modport slave (
    input  op_valid, funct, abort,
    output mul_load, mul_step, hilo_we, sel_out, busy, stall, done
  );
endinterface

// File: rtl/mult_step_counter.sv
// WIDTH-bound step counter: clear wins over enable, saturates at WIDTH-1.
module mult_step_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CntW'(WIDTH - 1));

  // Next count: clear, else advance until the last step and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !last_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multu_sequencer.sv
// Sequencing FSM for the shift-add MULTU unit and HI/LO write, with hazard stalls.
module multu_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter funct_t      FUNCT_MULTU = FunctMultu,
  parameter funct_t      FUNCT_MFHI  = FunctMfhi,
  parameter funct_t      FUNCT_MFLO  = FunctMflo,
  parameter funct_t      OUT_CODE    = FunctOut
) (
  input logic clk,
  input logic rst_n,
  multu_sequencer_if.slave bus
);

  seq_state_e state_q, state_d;
  logic       last_step;
  logic       cnt_clr;
  logic       cnt_en;
  logic       is_multu;
  logic       is_hilo_op;

  logic   mul_load, mul_step, hilo_we, busy, stall, done;
  funct_t sel_out;

  assign is_multu   = bus.op_valid && (bus.funct == FUNCT_MULTU);
  assign is_hilo_op = bus.op_valid &&
                      ((bus.funct == FUNCT_MULTU) || (bus.funct == FUNCT_MFHI) ||
                       (bus.funct == FUNCT_MFLO));

  // Counter only runs in RUN; any other state or an abort parks it at zero.
  assign cnt_clr = (state_q != StRun) || bus.abort;
  assign cnt_en  = (state_q == StRun);

  mult_step_counter #(
    .WIDTH(WIDTH)
  ) u_step_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .last_o(last_step)
  );

  // Next-state logic; abort returns to IDLE from any busy state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (is_multu && !bus.abort) state_d = StLoad;
      StLoad:  state_d = bus.abort ? StIdle : StRun;
      StRun: begin
        if (bus.abort)      state_d = StIdle;
        else if (last_step) state_d = StWrite;
      end
      StWrite: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode; the IDLE pass-through is gated so reset forces sel_out to zero.
  always_comb begin
    mul_load = 1'b0;
    mul_step = 1'b0;
    hilo_we  = 1'b0;
    done     = 1'b0;
    sel_out  = '0;
    busy     = (state_q != StIdle);
    unique case (state_q)
      StIdle:  sel_out = (rst_n && bus.op_valid) ? bus.funct : '0;
      StLoad: begin
        mul_load = 1'b1;
        sel_out  = FUNCT_MULTU;
      end
      StRun: begin
        mul_step = 1'b1;
        sel_out  = FUNCT_MULTU;
      end
      StWrite: begin
        // An aborted multiply must never reach HI/LO.
        hilo_we = !bus.abort;
        done    = !bus.abort;
        sel_out = OUT_CODE;
      end
    endcase
    stall = busy && is_hilo_op;
  end

  assign bus.mul_load = mul_load;
  assign bus.mul_step = mul_step;
  assign bus.hilo_we  = hilo_we;
  assign bus.done     = done;
  assign bus.busy     = busy;
  assign bus.stall    = stall;
  assign bus.sel_out  = sel_out;

endmodule

// File: tb/tb_multu_sequencer.sv
// Directed bench for multu_sequencer; cycle 0 is the cycle a MULTU is presented in IDLE.
module tb_multu_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  multu_sequencer_if bus ();

  multu_sequencer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {load, step, we, done, busy, stall, sel[5:0]}.
  function automatic logic [11:0] pk(logic ld, logic st, logic we, logic dn, logic bz,
                                     logic sl, logic [5:0] sel);
    return {ld, st, we, dn, bz, sl, sel};
  endfunction

  // Expected outputs c cycles after MULTU acceptance (c = 1..34).
  function automatic logic [11:0] exp_mul(int c, logic stl);
    return pk(c == 1, (c >= 2) && (c <= 33), c == 34, c == 34, 1'b1, stl,
              (c == 34) ? 6'd63 : 6'd25);
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [11:0] exp);
    logic [11:0] obs;
    #1;
    obs = pk(bus.mul_load, bus.mul_step, bus.hilo_we, bus.done, bus.busy, bus.stall,
             bus.sel_out);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic accept(string tag);
    bus.op_valid = 1'b1;
    bus.funct    = 6'd25;
    bus.abort    = 1'b0;
    chk(tag, pk(0, 0, 0, 0, 0, 0, 6'd25));
  endtask

  initial begin
    logic [5:0] pt_functs [6];
    pt_functs = '{6'd32, 6'd34, 6'd42, 6'd2, 6'd36, 6'd37};
    n_cmp = 0;
    n_err = 0;

    // Reset: outputs zero even with a MULTU presented.
    rst_n        = 1'b0;
    bus.op_valid = 1'b1;
    bus.funct    = 6'd25;
    bus.abort    = 1'b0;
    #3;
    chk("reset", 12'h000);
    nxt();
    chk("reset_held", 12'h000);
    bus.op_valid = 1'b0;
    #1 rst_n = 1'b1;

    // Single multiply.
    nxt();
    accept("t1_accept");
    for (int c = 1; c <= 34; c++) begin
      nxt();
      bus.op_valid = 1'b0;
      chk($sformatf("t1_c%0d", c), exp_mul(c, 1'b0));
    end
    nxt();
    chk("t1_idle", 12'h000);

    // HI read hazard: MFHI held from cycle 5.
    nxt();
    accept("t2_accept");
    for (int c = 1; c <= 34; c++) begin
      nxt();
      bus.op_valid = (c >= 5);
      bus.funct    = 6'd16;
      chk($sformatf("t2_c%0d", c), exp_mul(c, c >= 5));
    end
    nxt();
    chk("t2_release", pk(0, 0, 0, 0, 0, 0, 6'd16));
    bus.op_valid = 1'b0;

    // Back-to-back: second MULTU held from cycle 3.
    nxt();
    accept("t3_accept");
    for (int c = 1; c <= 35; c++) begin
      nxt();
      bus.op_valid = (c >= 3);
      bus.funct    = 6'd25;
      if (c <= 34) chk($sformatf("t3_c%0d", c), exp_mul(c, c >= 3));
      else         chk("t3_second_accept", pk(0, 0, 0, 0, 0, 0, 6'd25));
    end
    for (int c = 36; c <= 69; c++) begin
      nxt();
      bus.op_valid = 1'b0;
      chk($sformatf("t3_c%0d", c), exp_mul(c - 35, 1'b0));
    end
    nxt();
    chk("t3_idle", 12'h000);

    // Abort during RUN at cycle 11, restart at cycle 14.
    nxt();
    accept("t4_accept");
    for (int c = 1; c <= 11; c++) begin
      nxt();
      bus.op_valid = 1'b0;
      bus.abort    = (c == 11);
      chk($sformatf("t4_c%0d", c), exp_mul(c, 1'b0));
    end
    nxt();
    bus.abort = 1'b0;
    chk("t4_c12_idle", 12'h000);
    nxt();
    chk("t4_c13_idle", 12'h000);
    nxt();
    accept("t4_restart");
    for (int c = 1; c <= 34; c++) begin
      nxt();
      bus.op_valid = 1'b0;
      chk($sformatf("t4r_c%0d", c), exp_mul(c, 1'b0));
    end
    nxt();
    chk("t4_idle", 12'h000);

    // Abort during WRITE suppresses hilo_we and done.
    nxt();
    accept("t5_accept");
    for (int c = 1; c <= 34; c++) begin
      nxt();
      bus.op_valid = 1'b0;
      bus.abort    = (c == 34);
      if (c < 34) chk($sformatf("t5_c%0d", c), exp_mul(c, 1'b0));
      else        chk("t5_abort_write", pk(0, 0, 0, 0, 1, 0, 6'd63));
    end
    nxt();
    bus.abort = 1'b0;
    chk("t5_idle", 12'h000);

    // Abort in IDLE blocks a same-cycle MULTU.
    nxt();
    bus.op_valid = 1'b1;
    bus.funct    = 6'd25;
    bus.abort    = 1'b1;
    chk("t6_abort_idle", pk(0, 0, 0, 0, 0, 0, 6'd25));
    nxt();
    bus.op_valid = 1'b0;
    bus.abort    = 1'b0;
    chk("t6_not_accepted", 12'h000);

    // Asynchronous reset mid-RUN at cycle 20.
    nxt();
    accept("t7_accept");
    for (int c = 1; c <= 20; c++) begin
      nxt();
      bus.op_valid = 1'b0;
      chk($sformatf("t7_c%0d", c), exp_mul(c, 1'b0));
    end
    #2;
    rst_n        = 1'b0;
    bus.op_valid = 1'b1;
    bus.funct    = 6'd25;
    chk("t7_async_reset", 12'h000);
    nxt();
    chk("t7_reset_held", 12'h000);
    bus.op_valid = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk($sformatf("t7_post_%0d", k), 12'h000);
    end

    // IDLE pass-through of non-multiply functs, and op_valid=0 ignored.
    foreach (pt_functs[i]) begin
      nxt();
      bus.op_valid = 1'b1;
      bus.funct    = pt_functs[i];
      chk($sformatf("t8_pass_%0d", pt_functs[i]), pk(0, 0, 0, 0, 0, 0, pt_functs[i]));
    end
    nxt();
    bus.op_valid = 1'b0;
    bus.funct    = 6'd25;
    chk("t8_invalid_ignored", 12'h000);
    nxt();
    chk("t8_still_idle", 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
